lsu_dbus_bridge: RTL and testbench

// - Sits directly downstream of the LSU: takes its single-cycle DRAM-style request (aligned addr, byte we, re, din)
//   and runs it as a multi-cycle valid/ready transaction on the data bus, stalling the pipeline until it completes.
// - Returns 64-bit read data to the LSU on the LSU's i_dram_dout input; the LSU does byte/half/word extraction itself.

---
 rtl/lsu_dbus_bridge.sv | 147 ++++++++++++++
 tb/tb_lsu_dbus_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dbus_bridge.sv
// Bridges the LSU's single-cycle DRAM-style request onto a valid/ready data bus, stalling the pipeline until done.
// Optional bus timeout with sticky error flag is enabled by defining DBUS_TIMEOUT_EN.
module lsu_dbus_bridge #(
    parameter int DRAM_AW     = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DRAM_AW-1:0] i_dram_addr,
    input  logic [7:0]         i_dram_we,
    input  logic               i_dram_re,
    input  logic [63:0]        i_dram_din,
    output logic [63:0]        o_dram_dout,
    output logic               o_stall,
    output logic               o_dbus_req_valid,
    input  logic               i_dbus_req_ready,
    output logic [DRAM_AW-1:0] o_dbus_addr,
    output logic [7:0]         o_dbus_we,
    output logic [63:0]        o_dbus_wdata,
    input  logic               i_dbus_rsp_valid,
`ifdef DBUS_TIMEOUT_EN
    input  logic [63:0]        i_dbus_rdata,
    output logic               o_dbus_err
`else
    input  logic [63:0]        i_dbus_rdata
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               req_valid_q, req_valid_d;
    logic [DRAM_AW-1:0] addr_q, addr_d;
    logic [7:0]         we_q, we_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        dout_q, dout_d;
    logic               req;

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // A store takes priority when both enables are present; a pure load latches we=0.
    assign req = i_dram_re | (|i_dram_we);

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
`ifdef DBUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d      = i_dram_addr;
                    we_d        = i_dram_we;
                    wdata_d     = i_dram_din;
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (i_dbus_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
`ifdef DBUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            WAIT: begin
                if (i_dbus_rsp_valid) begin
                    state_d = DONE;
                    if (we_q == 8'h00) begin
                        dout_d = i_dbus_rdata;
                    end
                end
`ifdef DBUS_TIMEOUT_EN
                // Expiry on the last allowed WAIT cycle; a response in that same cycle wins above.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (we_q == 8'h00) begin
                        dout_d = 64'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                // The LSU still shows the finished request this cycle; never reissue it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 8'h00;
            wdata_q     <= 64'h0;
            dout_q      <= 64'h0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
`ifdef DBUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_stall          = ((state_q == IDLE) & req) | (state_q == REQ) | (state_q == WAIT);
    assign o_dbus_req_valid = req_valid_q;
    assign o_dbus_addr      = addr_q;
    assign o_dbus_we        = we_q;
    assign o_dbus_wdata     = wdata_q;
    assign o_dram_dout      = dout_q;
`ifdef DBUS_TIMEOUT_EN
    assign o_dbus_err       = err_q;
`endif

endmodule

// File: tb/tb_lsu_dbus_bridge.sv
// Directed bench for lsu_dbus_bridge; inputs change on the falling edge and outputs are checked 1ns later.
module tb_lsu_dbus_bridge;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_dram_addr;
    logic [7:0]    i_dram_we;
    logic          i_dram_re;
    logic [63:0]   i_dram_din;
    logic [63:0]   o_dram_dout;
    logic          o_stall;
    logic          o_dbus_req_valid;
    logic          i_dbus_req_ready;
    logic [AW-1:0] o_dbus_addr;
    logic [7:0]    o_dbus_we;
    logic [63:0]   o_dbus_wdata;
    logic          i_dbus_rsp_valid;
    logic [63:0]   i_dbus_rdata;
`ifdef DBUS_TIMEOUT_EN
    logic          o_dbus_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    lsu_dbus_bridge #(.DRAM_AW(AW), .TIMEOUT_CYC(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_dram_addr      (i_dram_addr),
        .i_dram_we        (i_dram_we),
        .i_dram_re        (i_dram_re),
        .i_dram_din       (i_dram_din),
        .o_dram_dout      (o_dram_dout),
        .o_stall          (o_stall),
        .o_dbus_req_valid (o_dbus_req_valid),
        .i_dbus_req_ready (i_dbus_req_ready),
        .o_dbus_addr      (o_dbus_addr),
        .o_dbus_we        (o_dbus_we),
        .o_dbus_wdata     (o_dbus_wdata),
        .i_dbus_rsp_valid (i_dbus_rsp_valid),
`ifdef DBUS_TIMEOUT_EN
        .i_dbus_rdata     (i_dbus_rdata),
        .o_dbus_err       (o_dbus_err)
`else
        .i_dbus_rdata     (i_dbus_rdata)
`endif
    );

    always @(posedge clk) begin
        if (!rst && o_dbus_req_valid && i_dbus_req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_dram_addr = '0; i_dram_we = 8'h00; i_dram_re = 1'b0; i_dram_din = 64'h0;
        i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b0; i_dbus_rdata = 64'h0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        n_checks++;
        if (o_dbus_req_valid !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: req_valid=%b stall=%b required 0 0", o_dbus_req_valid, o_stall);
        end
        n_checks++;
        if (o_dbus_addr !== 64'h0 || o_dbus_we !== 8'h00 || o_dbus_wdata !== 64'h0 || o_dram_dout !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h we=%h wdata=%h dout=%h required all 0",
                               o_dbus_addr, o_dbus_we, o_dbus_wdata, o_dram_dout);
        end
`ifdef DBUS_TIMEOUT_EN
        n_checks++;
        if (o_dbus_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: err=%b required 0", o_dbus_err);
        end
`endif
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            cyc(); settle();
            n_checks++;
            if (o_stall !== 1'b0 || o_dbus_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle[%0d]: stall=%b req_valid=%b required 0 0", i, o_stall, o_dbus_req_valid);
            end
        end
    endtask

    task automatic test_min_load();
        int hs0;
        hs0 = hs_cnt;
        // cycle 0: request appears in IDLE
        cyc(); i_dram_re = 1'b1; i_dram_addr = 64'h8000_0008; settle();
        n_checks++;
        if (o_stall !== 1'b1 || o_dbus_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_c0: stall=%b req_valid=%b required 1 0", o_stall, o_dbus_req_valid);
        end
        // cycle 1: REQ, ready immediately
        cyc(); i_dbus_req_ready = 1'b1; settle();
        n_checks++;
        if (o_stall !== 1'b1 || o_dbus_req_valid !== 1'b1 || o_dbus_addr !== 64'h8000_0008 || o_dbus_we !== 8'h00) begin
            n_fail++; $display("FAIL load_c1: stall=%b req_valid=%b addr=%h we=%h required 1 1 80000008 00",
                               o_stall, o_dbus_req_valid, o_dbus_addr, o_dbus_we);
        end
        // cycle 2: WAIT, response arrives
        cyc(); i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = 64'h1122_3344_5566_7788; settle();
        n_checks++;
        if (o_stall !== 1'b1 || o_dbus_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_c2: stall=%b req_valid=%b required 1 0", o_stall, o_dbus_req_valid);
        end
        // cycle 3: DONE
        cyc(); i_dbus_rsp_valid = 1'b0; i_dbus_rdata = 64'hDEAD_BEEF_DEAD_BEEF; settle();
        n_checks++;
        if (o_stall !== 1'b0 || o_dram_dout !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL load_c3: stall=%b dout=%h required 0 1122334455667788", o_stall, o_dram_dout);
        end
        cyc(); i_dram_re = 1'b0; settle();
        n_checks++;
        if (o_stall !== 1'b0 || o_dbus_req_valid !== 1'b0 || hs_cnt != hs0 + 1) begin
            n_fail++; $display("FAIL load_end: stall=%b req_valid=%b handshakes=%0d required 0 0 1",
                               o_stall, o_dbus_req_valid, hs_cnt - hs0);
        end
    endtask

    task automatic test_store_backpressure();
        int hs0;
        hs0 = hs_cnt;
        cyc(); i_dram_we = 8'hF0; i_dram_din = 64'hAABB_CCDD_AABB_CCDD; i_dram_addr = 64'h40; settle();
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) i_dbus_req_ready = 1'b1;
            // LSU fields wiggle while stalled; latched copies must not
            i_dram_din = 64'h0123_4567_89AB_CDEF + 64'(i);
            settle();
            n_checks++;
            if (o_dbus_req_valid !== 1'b1 || o_stall !== 1'b1 || o_dbus_addr !== 64'h40 ||
                o_dbus_we !== 8'hF0 || o_dbus_wdata !== 64'hAABB_CCDD_AABB_CCDD) begin
                n_fail++; $display("FAIL store_req[%0d]: valid=%b stall=%b addr=%h we=%h wdata=%h required 1 1 40 f0 aabbccddaabbccdd",
                                   i, o_dbus_req_valid, o_stall, o_dbus_addr, o_dbus_we, o_dbus_wdata);
            end
        end
        cyc(); i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = 64'h5555_5555_5555_5555; settle();
        n_checks++;
        if (o_dbus_req_valid !== 1'b0 || o_stall !== 1'b1) begin
            n_fail++; $display("FAIL store_wait: valid=%b stall=%b required 0 1", o_dbus_req_valid, o_stall);
        end
        cyc(); i_dbus_rsp_valid = 1'b0; settle();
        n_checks++;
        if (o_stall !== 1'b0 || o_dram_dout !== 64'h1122_3344_5566_7788 || hs_cnt != hs0 + 1) begin
            n_fail++; $display("FAIL store_done: stall=%b dout=%h handshakes=%0d required 0 1122334455667788 1",
                               o_stall, o_dram_dout, hs_cnt - hs0);
        end
        cyc(); i_dram_we = 8'h00; settle();
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = hs_cnt;
        cyc(); i_dram_re = 1'b1; i_dram_addr = 64'h100;
        cyc(); i_dbus_req_ready = 1'b1;
        cyc(); i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = 64'hCAFE_F00D_0000_0100;
        // DONE: old load still visible on the LSU side
        cyc(); i_dbus_rsp_valid = 1'b0; settle();
        n_checks++;
        if (o_stall !== 1'b0 || o_dram_dout !== 64'hCAFE_F00D_0000_0100) begin
            n_fail++; $display("FAIL b2b_done1: stall=%b dout=%h required 0 cafef00d00000100", o_stall, o_dram_dout);
        end
        // IDLE: next op is the store; re also set so store priority is exercised
        cyc(); i_dram_we = 8'hFF; i_dram_addr = 64'h108; i_dram_din = 64'h0F0F_0F0F_0F0F_0F0F; settle();
        n_checks++;
        if (o_stall !== 1'b1 || o_dbus_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: stall=%b req_valid=%b required 1 0", o_stall, o_dbus_req_valid);
        end
        cyc(); i_dbus_req_ready = 1'b1; settle();
        n_checks++;
        if (o_dbus_req_valid !== 1'b1 || o_dbus_addr !== 64'h108 || o_dbus_we !== 8'hFF ||
            o_dbus_wdata !== 64'h0F0F_0F0F_0F0F_0F0F) begin
            n_fail++; $display("FAIL b2b_req2: valid=%b addr=%h we=%h wdata=%h required 1 108 ff 0f0f0f0f0f0f0f0f",
                               o_dbus_req_valid, o_dbus_addr, o_dbus_we, o_dbus_wdata);
        end
        cyc(); i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = 64'h9999_9999_9999_9999;
        cyc(); i_dbus_rsp_valid = 1'b0; settle();
        n_checks++;
        if (o_stall !== 1'b0 || o_dram_dout !== 64'hCAFE_F00D_0000_0100) begin
            n_fail++; $display("FAIL b2b_done2: stall=%b dout=%h required 0 cafef00d00000100", o_stall, o_dram_dout);
        end
        cyc(); i_dram_we = 8'h00; i_dram_re = 1'b0; settle();
        cyc(); settle();
        n_checks++;
        if (hs_cnt != hs0 + 2 || o_dbus_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count: handshakes=%0d req_valid=%b required 2 0", hs_cnt - hs0, o_dbus_req_valid);
        end
    endtask

    task automatic test_reset_mid();
        cyc(); i_dram_re = 1'b1; i_dram_addr = 64'h200;
        cyc(); i_dbus_req_ready = 1'b1;
        cyc(); i_dbus_req_ready = 1'b0; rst = 1'b1; settle();
        n_checks++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_wait: stall=%b required 1", o_stall);
        end
        cyc(); rst = 1'b0; i_dram_re = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = 64'h7777_7777_7777_7777; settle();
        n_checks++;
        if (o_dbus_req_valid !== 1'b0 || o_stall !== 1'b0 || o_dram_dout !== 64'h0 || o_dbus_addr !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_after: valid=%b stall=%b dout=%h addr=%h required 0 0 0 0",
                               o_dbus_req_valid, o_stall, o_dram_dout, o_dbus_addr);
        end
        cyc(); i_dbus_rsp_valid = 1'b0; settle();
        n_checks++;
        if (o_dram_dout !== 64'h0 || o_stall !== 1'b0 || o_dbus_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_late_rsp: dout=%h stall=%b valid=%b required 0 0 0",
                               o_dram_dout, o_stall, o_dbus_req_valid);
        end
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic do_load(input logic [63:0] addr, input logic [63:0] data);
        cyc(); i_dram_re = 1'b1; i_dram_addr = addr;
        cyc(); i_dbus_req_ready = 1'b1;
        cyc(); i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b1; i_dbus_rdata = data;
        cyc(); i_dbus_rsp_valid = 1'b0;
        cyc(); i_dram_re = 1'b0;
    endtask

    task automatic test_timeout();
        do_load(64'h280, 64'h4444_3333_2222_1111);
        cyc(); i_dram_re = 1'b1; i_dram_addr = 64'h300;
        cyc(); i_dbus_req_ready = 1'b1;
        cyc(); i_dbus_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            n_checks++;
            if (o_stall !== 1'b1 || o_dbus_err !== 1'b0) begin
                n_fail++; $display("FAIL to_wait[%0d]: stall=%b err=%b required 1 0", i, o_stall, o_dbus_err);
            end
            cyc();
        end
        settle();
        n_checks++;
        if (o_dbus_err !== 1'b1 || o_stall !== 1'b0 || o_dram_dout !== 64'h0) begin
            n_fail++; $display("FAIL to_done: err=%b stall=%b dout=%h required 1 0 0", o_dbus_err, o_stall, o_dram_dout);
        end
        cyc(); i_dram_re = 1'b0;
        do_load(64'h308, 64'h8888_6666_4444_2222);
        settle();
        n_checks++;
        if (o_dbus_err !== 1'b1 || o_dram_dout !== 64'h8888_6666_4444_2222) begin
            n_fail++; $display("FAIL to_sticky: err=%b dout=%h required 1 8888666644442222", o_dbus_err, o_dram_dout);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_min_load();
        test_store_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef DBUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
